// File: rtl/time_counter.sv
// Free-running hh:mm:ss time-of-day counter.
// Reports the current time on data_ch. Loads an edited time from setup_data on each
// rising edge of setup_imp. Emits 1 Hz (sec_tick) and midnight (day_wrap) pulses.
// Optional build macro TIME_HOLD_EN: freezes the prescaler while rezhim == 3.

module time_counter #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] setup_data,
    input  logic        setup_imp,
    input  logic [1:0]  rezhim,
    output logic [23:0] data_ch,
    output logic        sec_tick,
    output logic        day_wrap
);

    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PreLast = PW'(CLK_FREQ - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [23:0]   time_q, time_d;
    logic          setup_imp_q;
    logic          sec_tick_q, day_wrap_q;

    logic          hold;
    logic          tick;
    logic          ld;

    logic [7:0]    hh, mm, ss;
    logic [7:0]    hh_adv, mm_adv, ss_adv;
    logic          wrap_adv;
    logic [7:0]    hh_ld, mm_ld, ss_ld;

`ifdef TIME_HOLD_EN
    // Setup mode pauses the second count without losing the partial second.
    assign hold = (rezhim == 2'd3);
`else
    // Mode input has no effect in this build.
    logic unused_rezhim;
    assign unused_rezhim = ^rezhim;
    assign hold = 1'b0;
`endif

    assign ld   = setup_imp & ~setup_imp_q;
    assign tick = (prescaler_q == PreLast) & ~hold;

    assign hh = time_q[23:16];
    assign mm = time_q[15:8];
    assign ss = time_q[7:0];

    // One-second advance with carries through minutes, hours and midnight.
    always_comb begin
        ss_adv   = ss + 8'd1;
        mm_adv   = mm;
        hh_adv   = hh;
        wrap_adv = 1'b0;
        if (ss == 8'd59) begin
            ss_adv = 8'd0;
            mm_adv = mm + 8'd1;
            if (mm == 8'd59) begin
                mm_adv = 8'd0;
                hh_adv = hh + 8'd1;
                if (hh == 8'd23) begin
                    hh_adv   = 8'd0;
                    wrap_adv = 1'b1;
                end
            end
        end
    end

    // Out-of-range load fields are forced to zero independently.
    always_comb begin
        hh_ld = (setup_data[23:16] > 8'd23) ? 8'd0 : setup_data[23:16];
        mm_ld = (setup_data[15:8]  > 8'd59) ? 8'd0 : setup_data[15:8];
        ss_ld = (setup_data[7:0]   > 8'd59) ? 8'd0 : setup_data[7:0];
    end

    // Next prescaler and time; a load overrides a coincident tick.
    always_comb begin
        prescaler_d = prescaler_q;
        time_d      = time_q;
        if (ld) begin
            prescaler_d = '0;
            time_d      = {hh_ld, mm_ld, ss_ld};
        end else if (hold) begin
            prescaler_d = prescaler_q;
        end else if (tick) begin
            prescaler_d = '0;
            time_d      = {hh_adv, mm_adv, ss_adv};
        end else begin
            prescaler_d = prescaler_q + PW'(1);
        end
    end

    // State registers and registered pulse outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler_q <= '0;
            time_q      <= 24'h000000;
            setup_imp_q <= 1'b0;
            sec_tick_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            time_q      <= time_d;
            setup_imp_q <= setup_imp;
            sec_tick_q  <= tick & ~ld;
            day_wrap_q  <= tick & ~ld & wrap_adv;
        end
    end

    assign data_ch  = time_q;
    assign sec_tick = sec_tick_q;
    assign day_wrap = day_wrap_q;

endmodule
